// File: rtl/cnt_sched_pkg.sv
// Shared types and limits for the counter command scheduler: opcodes,
// FSM states and the inter-pulse gap bound.
package cnt_sched_pkg;

  localparam int ARG_W         = 4;
  localparam int PULSE_GAP_MAX = 7;
  localparam int GAP_W         = 3;

  typedef enum logic [1:0] {
    OP_LOAD = 2'b00,
    OP_UP   = 2'b01,
    OP_DOWN = 2'b10,
    OP_NOP  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_GAP,
    ST_DONE
  } state_e;

  // UP and DOWN are the only opcodes that emit count pulses.
  function automatic logic is_step(op_e op);
    return (op == OP_UP) || (op == OP_DOWN);
  endfunction

endpackage

// File: rtl/counter_sched_if.sv
// Command handshake of one requester: valid/op/arg offered by the master,
// ready returned by the scheduler in the accept cycle.
interface counter_sched_if;
  import cnt_sched_pkg::*;

  logic             valid;
  logic [1:0]       op;
  logic [ARG_W-1:0] arg;
  logic             ready;

  modport master (output valid, output op, output arg, input ready);
  modport slave  (input valid, input op, input arg, output ready);

endinterface

// File: rtl/arb2.sv
// Two-way request arbiter. With CNT_SCHED_RR_EN defined it keeps a
// round-robin pointer; otherwise requester 0 has fixed priority.
module arb2 (
`ifdef CNT_SCHED_RR_EN
  input  logic       clk,
  input  logic       reset,
  input  logic       advance,
`endif
  input  logic [1:0] req,
  output logic [1:0] gnt
);

`ifdef CNT_SCHED_RR_EN
  // Holds the index granted last; starts at 1 so requester 0 wins first.
  logic last_gnt;

  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = last_gnt ? 2'b01 : 2'b10;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_gnt <= 1'b1;
    end else if (advance) begin
      last_gnt <= gnt[1];
    end
  end
`else
  assign gnt = {req[1] & ~req[0], req[0]};
`endif

endmodule

// File: rtl/counter_sched.sv
// Schedules LOAD/UP/DOWN/NOP commands from two requesters onto a 4-bit
// up/down counter. Arbitration mode selected by CNT_SCHED_RR_EN.
module counter_sched
  import cnt_sched_pkg::*;
#(
  parameter int PULSE_GAP = 0
) (
  input  logic             clk,
  input  logic             reset,
  counter_sched_if.slave   req0,
  counter_sched_if.slave   req1,
  output logic             count,
  output logic             up_down,
  output logic             load,
  output logic [ARG_W-1:0] load_input,
  output logic             busy,
  output logic             done,
  output logic             done_id
);

  localparam int GAP = (PULSE_GAP > PULSE_GAP_MAX) ? PULSE_GAP_MAX :
                       (PULSE_GAP < 0) ? 0 : PULSE_GAP;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP - 1);

  state_e           state;
  logic             id_q;
  logic [ARG_W-1:0] rem;
  logic [GAP_W-1:0] gap_cnt;

  logic [1:0]       req_vld;
  logic [1:0]       gnt;
  logic             accept;
  op_e              sel_op;
  logic [ARG_W-1:0] sel_arg;
  logic             sel_id;

  assign req_vld = {req1.valid, req0.valid};
  assign accept  = (state == ST_IDLE) && (|req_vld) && !reset;

  assign req0.ready = accept & gnt[0];
  assign req1.ready = accept & gnt[1];

  arb2 u_arb (
`ifdef CNT_SCHED_RR_EN
    .clk     (clk),
    .reset   (reset),
    .advance (accept),
`endif
    .req     (req_vld),
    .gnt     (gnt)
  );

  always_comb begin
    sel_id  = gnt[1];
    sel_op  = op_e'(gnt[1] ? req1.op : req0.op);
    sel_arg = gnt[1] ? req1.arg : req0.arg;
  end

  // Outputs are registered together with the state, so each output value
  // belongs to the state it is issued alongside.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      count      <= 1'b0;
      load       <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      done_id    <= 1'b0;
      up_down    <= 1'b1;
      load_input <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            state <= ST_EXEC;
            busy  <= 1'b1;
            id_q  <= sel_id;
            rem   <= sel_arg - ARG_W'(1);
            if (sel_op == OP_LOAD) begin
              load       <= 1'b1;
              load_input <= sel_arg;
            end else if (is_step(sel_op) && sel_arg != '0) begin
              count   <= 1'b1;
              up_down <= (sel_op == OP_UP);
            end
          end
        end

        ST_EXEC: begin
          load <= 1'b0;
          // rem counts pulses still owed after the one being issued now.
          if (count && rem != '0) begin
            if (GAP > 0) begin
              state   <= ST_GAP;
              count   <= 1'b0;
              gap_cnt <= GAP_LAST;
            end else begin
              rem <= rem - ARG_W'(1);
            end
          end else begin
            state   <= ST_DONE;
            count   <= 1'b0;
            done    <= 1'b1;
            done_id <= id_q;
          end
        end

        ST_GAP: begin
          if (gap_cnt == '0) begin
            state <= ST_EXEC;
            count <= 1'b1;
            rem   <= rem - ARG_W'(1);
          end else begin
            gap_cnt <= gap_cnt - GAP_W'(1);
          end
        end

        ST_DONE: begin
          state <= ST_IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_counter_sched.sv
// Bench for counter_sched: two instances (PULSE_GAP 0 and 2) driven by the
// same stimulus and compared every cycle against a command-trace model.
module tb_counter_sched;

  typedef struct {
    bit       cnt;
    bit       up;
    bit       ld;
    bit [3:0] lin;
    bit       dn;
    bit       did;
  } exp_t;

  typedef struct {
    bit       rq;
    bit [1:0] op;
    bit [3:0] arg;
    int       lat0;
    int       lat2;
    int       npulse;
  } vec_t;

  logic       clk;
  logic       reset;
  logic       v0, v1;
  logic [1:0] op0, op1;
  logic [3:0] arg0, arg1;

  logic [1:0] rdy0, rdy1, cnt_o, ud_o, ld_o, busy_o, done_o, did_o;
  logic [3:0] lin_o [2];

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    counter_sched_if r0 ();
    counter_sched_if r1 ();
    assign r0.valid = v0;
    assign r0.op    = op0;
    assign r0.arg   = arg0;
    assign r1.valid = v1;
    assign r1.op    = op1;
    assign r1.arg   = arg1;
    assign rdy0[gi] = r0.ready;
    assign rdy1[gi] = r1.ready;

    counter_sched #(.PULSE_GAP(gi * 2)) dut (
      .clk        (clk),
      .reset      (reset),
      .req0       (r0),
      .req1       (r1),
      .count      (cnt_o[gi]),
      .up_down    (ud_o[gi]),
      .load       (ld_o[gi]),
      .load_input (lin_o[gi]),
      .busy       (busy_o[gi]),
      .done       (done_o[gi]),
      .done_id    (did_o[gi])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_vec = 0;
  int   n_bad = 0;
  int   cyc   = 0;
  exp_t q [2][$];
`ifdef CNT_SCHED_RR_EN
  bit   last_g [2];
`endif
  int   acc_cyc [2];
  int   done_cyc [2];
  int   pulses [2];
  int   done_n [2];
  bit   did_seen [2];
  int   gq [$];

  task automatic chk(input string nm, input int d, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s dut%0d cycle %0d: got %0d expected %0d", nm, d, cyc, act, exp);
    end
  endtask

  // Expected per-cycle trace of one command, starting the cycle after accept.
  task automatic push_cmd(input int d, input bit [1:0] op, input bit [3:0] arg, input bit id);
    exp_t e;
    e = '{default: 0};
    if (op == 2'b00) begin
      e.ld = 1; e.lin = arg;
      q[d].push_back(e);
    end else if (op != 2'b11 && arg != 0) begin
      for (int i = 1; i <= int'(arg); i++) begin
        e = '{default: 0}; e.cnt = 1; e.up = (op == 2'b01);
        q[d].push_back(e);
        if (i < int'(arg)) begin
          for (int j = 0; j < d * 2; j++) begin
            e = '{default: 0};
            q[d].push_back(e);
          end
        end
      end
    end else begin
      q[d].push_back(e);
    end
    e = '{default: 0}; e.dn = 1; e.did = id;
    q[d].push_back(e);
  endtask

  task automatic model_check();
    for (int d = 0; d < 2; d++) begin
      exp_t     e;
      bit       busy_e;
      bit [1:0] g;
      e = '{default: 0}; busy_e = 0; g = 2'b00;
      if (q[d].size() != 0) begin
        e = q[d].pop_front();
        busy_e = 1;
      end else if (!reset && (v0 || v1)) begin
        if (v0 && v1) begin
`ifdef CNT_SCHED_RR_EN
          g = last_g[d] ? 2'b01 : 2'b10;
`else
          g = 2'b01;
`endif
        end else begin
          g = {v1, v0};
        end
`ifdef CNT_SCHED_RR_EN
        last_g[d] = g[1];
`endif
        push_cmd(d, g[1] ? op1 : op0, g[1] ? arg1 : arg0, g[1]);
      end
      chk("ready0", d, int'(rdy0[d]), int'(g[0]));
      chk("ready1", d, int'(rdy1[d]), int'(g[1]));
      chk("count",  d, int'(cnt_o[d]), int'(e.cnt));
      chk("load",   d, int'(ld_o[d]), int'(e.ld));
      chk("busy",   d, int'(busy_o[d]), int'(busy_e));
      chk("done",   d, int'(done_o[d]), int'(e.dn));
      if (e.cnt) chk("up_down", d, int'(ud_o[d]), int'(e.up));
      if (e.ld)  chk("load_input", d, int'(lin_o[d]), int'(e.lin));
      if (e.dn)  chk("done_id", d, int'(did_o[d]), int'(e.did));
      if (rdy0[d] || rdy1[d]) begin
        acc_cyc[d] = cyc;
        pulses[d]  = 0;
        if (d == 0) gq.push_back(int'(rdy1[d]));
      end
      if (cnt_o[d]) pulses[d]++;
      if (done_o[d]) begin
        done_cyc[d] = cyc;
        did_seen[d] = did_o[d];
        done_n[d]++;
      end
      if (reset) begin
        q[d].delete();
`ifdef CNT_SCHED_RR_EN
        last_g[d] = 1'b1;
`endif
      end
    end
    cyc++;
  endtask

  task automatic cycle_in(input bit rs, input bit a_v0, input bit [1:0] a_op0, input bit [3:0] a_arg0,
                          input bit a_v1, input bit [1:0] a_op1, input bit [3:0] a_arg1);
    reset = rs;
    v0 = a_v0; op0 = a_op0; arg0 = a_arg0;
    v1 = a_v1; op1 = a_op1; arg1 = a_arg1;
    @(negedge clk);
    model_check();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle();
    cycle_in(0, 0, 2'($urandom), 4'($urandom), 0, 2'($urandom), 4'($urandom));
  endtask

  // One command from an idle start, then wait (bounded) for done on both DUTs.
  task automatic apply_cmd(input vec_t v);
    for (int d = 0; d < 2; d++) begin
      acc_cyc[d] = -1; done_cyc[d] = -1; pulses[d] = 0; did_seen[d] = 0;
    end
    cycle_in(0, !v.rq, v.op, v.arg, v.rq, v.op, v.arg);
    for (int k = 0; k < 80 && (done_cyc[0] < 0 || done_cyc[1] < 0); k++) idle_cycle();
    for (int d = 0; d < 2; d++) begin
      int lat;
      lat = (acc_cyc[d] >= 0 && done_cyc[d] >= 0) ? done_cyc[d] - acc_cyc[d] + 1 : -1;
      chk("latency", d, lat, (d == 0) ? v.lat0 : v.lat2);
      chk("pulse_count", d, pulses[d], v.npulse);
      chk("done_id_final", d, int'(did_seen[d]), int'(v.rq));
    end
  endtask

  vec_t tbl [7];

  initial begin
    tbl[0] = '{rq: 0, op: 2'b00, arg: 4'd9,  lat0: 3,  lat2: 3,  npulse: 0};
    tbl[1] = '{rq: 1, op: 2'b01, arg: 4'd3,  lat0: 5,  lat2: 9,  npulse: 3};
    tbl[2] = '{rq: 0, op: 2'b10, arg: 4'd2,  lat0: 4,  lat2: 6,  npulse: 2};
    tbl[3] = '{rq: 0, op: 2'b10, arg: 4'd0,  lat0: 3,  lat2: 3,  npulse: 0};
    tbl[4] = '{rq: 1, op: 2'b01, arg: 4'd15, lat0: 17, lat2: 45, npulse: 15};
    tbl[5] = '{rq: 1, op: 2'b11, arg: 4'd5,  lat0: 3,  lat2: 3,  npulse: 0};
    tbl[6] = '{rq: 0, op: 2'b01, arg: 4'd1,  lat0: 3,  lat2: 3,  npulse: 1};

    reset = 1; v0 = 0; v1 = 0; op0 = 0; op1 = 0; arg0 = 0; arg1 = 0;
    for (int d = 0; d < 2; d++) begin
      done_n[d] = 0;
`ifdef CNT_SCHED_RR_EN
      last_g[d] = 1'b1;
`endif
    end
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("rst_up_down", d, int'(ud_o[d]), 1);
      chk("rst_load_input", d, int'(lin_o[d]), 0);
      chk("rst_busy", d, int'(busy_o[d]), 0);
      chk("rst_count", d, int'(cnt_o[d]), 0);
      chk("rst_done", d, int'(done_o[d]), 0);
    end
    reset = 0;
    idle_cycle();

    foreach (tbl[i]) apply_cmd(tbl[i]);

    // DOWN 2: the PULSE_GAP=2 instance must show count 1,0,0,1 going down.
    begin
      bit [3:0] pat;
      pat = 4'b0000;
      cycle_in(0, 1, 2'b10, 4'd2, 0, 2'b00, 4'd0);
      for (int k = 0; k < 4; k++) begin
        pat = {pat[2:0], cnt_o[1]};
        if (cnt_o[1]) chk("gap_dir", 1, int'(ud_o[1]), 0);
        idle_cycle();
      end
      chk("gap_pattern", 1, int'(pat), 4'b1001);
      repeat (3) idle_cycle();
    end

    // Continuous contention with NOPs.
    gq.delete();
    repeat (13) cycle_in(0, 1, 2'b11, 4'd0, 1, 2'b11, 4'd0);
    repeat (4) idle_cycle();
    chk("grant_count", 0, int'(gq.size() >= 4), 1);
    for (int i = 0; i < 4 && i < gq.size(); i++) begin
`ifdef CNT_SCHED_RR_EN
      chk("grant_order", 0, gq[i], i % 2);
`else
      chk("grant_order", 0, gq[i], 0);
`endif
    end

    // Reset during the second pulse of UP 5 aborts silently.
    done_n[0] = 0; done_n[1] = 0;
    cycle_in(0, 1, 2'b01, 4'd5, 0, 2'b00, 4'd0);
    idle_cycle();
    cycle_in(1, 0, 2'b00, 4'd0, 0, 2'b00, 4'd0);
    chk("abort_count", 0, int'(cnt_o[0]), 0);
    chk("abort_busy", 0, int'(busy_o[0]), 0);
    chk("abort_busy", 1, int'(busy_o[1]), 0);
    repeat (6) idle_cycle();
    chk("abort_no_done", 0, done_n[0], 0);
    chk("abort_no_done", 1, done_n[1], 0);
    apply_cmd('{rq: 0, op: 2'b00, arg: 4'd6, lat0: 3, lat2: 3, npulse: 0});

    // Random traffic, including occasional resets.
    for (int k = 0; k < 500; k++) begin
      cycle_in($urandom_range(0, 63) == 0,
               $urandom_range(0, 2) != 0, 2'($urandom), 4'($urandom_range(0, 5)),
               $urandom_range(0, 2) != 0, 2'($urandom), 4'($urandom_range(0, 5)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/counter_sched.md
COUNTER_SCHED -- requirements
Module: counter_sched

Interface
REQ-001 Parameter: PULSE_GAP, default 0, idle cycles inserted between consecutive count pulses (0..7).
REQ-002 Port: clk  in  1  single clock, all logic on rising edge.
REQ-003 Port: reset  in  1  synchronous, active-high reset.
REQ-004 Port: req0_valid  in  1  requester 0 has a command.
REQ-005 Port: req0_op  in  2  requester 0 opcode: 00 LOAD, 01 UP, 10 DOWN, 11 NOP.
REQ-006 Port: req0_arg  in  4  requester 0 argument: load value or step count.
REQ-007 Port: req0_ready  out  1  requester 0 command accepted this cycle.
REQ-008 Port: req1_valid / req1_op / req1_arg / req1_ready  same widths and meaning for requester 1.
REQ-009 Port: count  out  1  counter enable pulse to the 4-bit up/down counter.
REQ-010 Port: up_down  out  1  counter direction, 1 = up.
REQ-011 Port: load  out  1  counter parallel-load strobe.
REQ-012 Port: load_input  out  4  counter parallel-load value.
REQ-013 Port: busy  out  1  a command is being executed.
REQ-014 Port: done  out  1  one-cycle completion pulse.
REQ-015 Port: done_id  out  1  requester index of the completed command, valid with done.

Function
REQ-016 FSM states: IDLE, EXEC, GAP, DONE.
REQ-017 IDLE: if any valid, grant one requester, assert its ready for exactly that cycle, latch op/arg/id, and go to EXEC next cycle.
REQ-018 ready is never asserted outside IDLE, and never to both requesters in the same cycle.
REQ-019 LOAD: in the single EXEC cycle, load=1 and load_input=latched arg; then go to DONE.
REQ-020 UP/DOWN: each EXEC cycle drives count=1 with up_down=1 (UP) or 0 (DOWN) and decrements the remaining count; after the last pulse go to DONE.
REQ-021 UP/DOWN with PULSE_GAP>0: go to GAP for exactly PULSE_GAP cycles (count=0) between pulses; no GAP after the last pulse.
REQ-022 UP/DOWN with arg=0, and NOP: no counter activity; EXEC lasts one cycle, then DONE.
REQ-023 DONE: done=1 and done_id=latched id for one cycle, then return to IDLE; the next grant occurs no earlier than that IDLE cycle.
REQ-024 Latency: UP n steps (n>=1) runs from accept to done in 1+n+(n-1)*PULSE_GAP+1 cycles; LOAD in 3 cycles.
REQ-025 busy=1 in EXEC, GAP, and DONE; busy=0 in IDLE.
REQ-026 load and count are never high in the same cycle; up_down holds its value outside UP/DOWN execution.
REQ-027 Requester inputs are sampled only in the accept cycle; changes during execution have no effect.

Reset
REQ-028 reset=1 at a clock edge: state=IDLE; count, load, busy, done, done_id, req*_ready=0; up_down=1; load_input=0; round-robin pointer favours requester 0.
REQ-029 Reset during EXEC/GAP aborts the command with no done pulse and no further counter pulses from the next cycle on.

Configuration
REQ-030 CNT_SCHED_RR_EN defined: round-robin arbitration; on contention the requester not granted last wins, and the pointer updates on each grant.
REQ-031 CNT_SCHED_RR_EN undefined: fixed priority, requester 0 always wins contention; pointer logic absent.

Structure
REQ-032 Shared package cnt_sched_pkg: opcode constants, FSM state type, and the PULSE_GAP maximum.
REQ-033 Sub-module arb2 (2-way arbiter with optional round-robin pointer) instantiated once; all other logic lives in counter_sched.

Verification
REQ-034 req0 LOAD arg=9 from reset: ready0 in cycle 0, load=1 and load_input=9 in cycle 1, done=1 and done_id=0 in cycle 2.
REQ-035 req1 UP arg=3, PULSE_GAP=0: count=1 with up_down=1 for 3 consecutive cycles, done 1 cycle later, done_id=1.
REQ-036 req0 DOWN arg=2, PULSE_GAP=2: pattern count 1,0,0,1 with up_down=0, then done.
REQ-037 Both valid continuously, NOP: with RR_EN grants alternate 0,1,0,1; without it grants are always 0.
REQ-038 DOWN arg=0: no count pulse, done 2 cycles after ready; UP arg=15 yields exactly 15 pulses.
REQ-039 reset asserted in the 2nd pulse of UP arg=5: next cycle count=0, busy=0, no done; a new command is accepted normally after reset drops.
